// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_pipe
// Description : Pipelined RV immediate generator. Decodes the I/S/B/J/U,
//               shamt and CSR-zimm immediate formats, extends them to XLEN
//               and delivers them through a 2-entry skid buffer with
//               valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_pipe #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic            imm_err
);

    // Only RV32 and RV64 widths are meaningful, each with its matching shamt width.
    generate
        if (!((XLEN == 32 && SHAMT_W == 5) || (XLEN == 64 && SHAMT_W == 6))) begin : g_bad_param
            $error("imm_extend_pipe: XLEN must be 32 (SHAMT_W=5) or 64 (SHAMT_W=6)");
        end
    endgenerate

    // Format select codes.
    localparam logic [2:0] SRC_I     = 3'b000;
    localparam logic [2:0] SRC_S     = 3'b001;
    localparam logic [2:0] SRC_B     = 3'b010;
    localparam logic [2:0] SRC_J     = 3'b011;
    localparam logic [2:0] SRC_U     = 3'b100;
    localparam logic [2:0] SRC_SHAMT = 3'b101;
    localparam logic [2:0] SRC_ZIMM  = 3'b110;

    // State encodes {main_valid, skid_valid}; (0,1) is never entered.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   main_imm_q, main_imm_d;
    logic              main_err_q, main_err_d;
    logic [XLEN-1:0]   skid_imm_q, skid_imm_d;
    logic              skid_err_q, skid_err_d;

    logic [31:0]       instr_g;
    logic [31:0]       imm32;
    logic [XLEN-1:0]   new_imm;
    logic              new_err;
    logic              accept;
    logic              deliver;

    // Handshake outputs come straight from the state register, so in_ready has
    // no combinational dependence on out_ready.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = state_q[1];
    assign imm       = main_imm_q;
    assign imm_err   = main_err_q;

    assign accept  = in_valid & in_ready;
    assign deliver = out_valid & out_ready;

    // Decode and extend the incoming immediate; the instruction is masked when
    // not valid so undefined bits never reach the datapath.
    always_comb begin
        instr_g = in_valid ? instr : 32'b0;
        imm32   = 32'b0;
        new_imm = '0;
        new_err = 1'b0;
        case (imm_src)
            SRC_I:     imm32 = {{20{instr_g[31]}}, instr_g[31:20]};
            SRC_S:     imm32 = {{20{instr_g[31]}}, instr_g[31:25], instr_g[11:7]};
            SRC_B:     imm32 = {{20{instr_g[31]}}, instr_g[7], instr_g[30:25],
                                instr_g[11:8], 1'b0};
            SRC_J:     imm32 = {{12{instr_g[31]}}, instr_g[19:12], instr_g[20],
                                instr_g[30:21], 1'b0};
            SRC_U:     imm32 = {instr_g[31:12], 12'b0};
            default:   imm32 = 32'b0;
        endcase
        case (imm_src)
            SRC_SHAMT: new_imm = XLEN'(instr_g[20 +: SHAMT_W]);
            SRC_ZIMM:  new_imm = XLEN'(instr_g[19:15]);
            3'b111: begin
                new_imm = '0;
                new_err = 1'b1;
            end
            // Sign-extending formats: the 32-bit result already carries the
            // sign in bit 31, so a signed widening cast completes the job.
            default:   new_imm = XLEN'($signed(imm32));
        endcase
    end

    // Next-state and register-load control for the main/skid pair.
    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_err_d = main_err_q;
        skid_imm_d = skid_imm_q;
        skid_err_d = skid_err_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d    = ST_ONE;
                    main_imm_d = new_imm;
                    main_err_d = new_err;
                end
            end
            ST_ONE: begin
                if (accept && deliver) begin
                    main_imm_d = new_imm;
                    main_err_d = new_err;
                end else if (accept) begin
                    state_d    = ST_FULL;
                    skid_imm_d = new_imm;
                    skid_err_d = new_err;
                end else if (deliver) begin
                    state_d    = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (deliver) begin
                    state_d    = ST_ONE;
                    main_imm_d = skid_imm_q;
                    main_err_d = skid_err_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State and data registers; reset clears everything including the output data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            main_imm_q <= '0;
            main_err_q <= 1'b0;
            skid_imm_q <= '0;
            skid_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_imm_q <= main_imm_d;
            main_err_q <= main_err_d;
            skid_imm_q <= skid_imm_d;
            skid_err_q <= skid_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_extend_pipe
// Description : Self-checking bench for imm_extend_pipe (XLEN=32 and XLEN=64
//               instances driven in lockstep).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = 32'b0;
    logic [2:0]  imm_src = 3'b0;
    logic        out_ready = 1'b0;

    logic        in_ready32, out_valid32, err32;
    logic [31:0] imm32;
    logic        in_ready64, out_valid64, err64;
    logic [63:0] imm64;

    int total = 0;
    int bad   = 0;

    imm_extend_pipe #(.XLEN(32), .SHAMT_W(5)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .imm_src(imm_src), .out_valid(out_valid32),
        .out_ready(out_ready), .imm(imm32), .imm_err(err32)
    );

    imm_extend_pipe #(.XLEN(64), .SHAMT_W(6)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .imm_src(imm_src), .out_valid(out_valid64),
        .out_ready(out_ready), .imm(imm64), .imm_err(err64)
    );

    always #5 clk = ~clk;

    // Expected 32-bit immediate for the random scoreboard.
    function automatic logic [31:0] ref32(input logic [31:0] i, input logic [2:0] s);
        case (s)
            3'd0: ref32 = {{20{i[31]}}, i[31:20]};
            3'd1: ref32 = {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2: ref32 = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3: ref32 = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd4: ref32 = {i[31:12], 12'b0};
            3'd5: ref32 = {27'b0, i[24:20]};
            3'd6: ref32 = {27'b0, i[19:15]};
            default: ref32 = 32'b0;
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; instr = 32'hFFF00093; imm_src = 3'd0; out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid32); end
        total++; if (in_ready32 !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready32); end
        total++; if (imm32 !== 32'h0) begin bad++; $display("FAIL reset_imm: got %h expected 0", imm32); end
        total++; if (err32 !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", err32); end
        total++; if (out_valid64 !== 1'b0) begin bad++; $display("FAIL reset_out_valid64: got %b expected 0", out_valid64); end
        reset = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_formats32();
        logic [31:0] v_instr [5] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h123450B7, 32'h001000EF};
        logic [2:0]  v_src   [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3};
        logic [31:0] v_exp   [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000800};
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; instr = v_instr[k]; imm_src = v_src[k];
            @(posedge clk); #1;
            total++;
            if (out_valid32 !== 1'b1 || imm32 !== v_exp[k] || err32 !== 1'b0) begin
                bad++;
                $display("FAIL fmt32_%0d: got v=%b imm=%h err=%b expected v=1 imm=%h err=0",
                         k, out_valid32, imm32, err32, v_exp[k]);
            end
            total++; if (in_ready32 !== 1'b1) begin bad++; $display("FAIL fmt32_ready_%0d: got %b expected 1", k, in_ready32); end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL fmt32_drain: got %b expected 0", out_valid32); end
    endtask

    task automatic test_xlen64();
        logic [31:0] v_instr [3] = '{32'h800000B7, 32'h03F0D093, 32'h3400D073};
        logic [2:0]  v_src   [3] = '{3'd4, 3'd5, 3'd6};
        logic [63:0] v_exp64 [3] = '{64'hFFFFFFFF80000000, 64'h3F, 64'h1};
        logic [31:0] v_exp32 [3] = '{32'h80000000, 32'h1F, 32'h1};
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; instr = v_instr[k]; imm_src = v_src[k];
            @(posedge clk); #1;
            total++;
            if (out_valid64 !== 1'b1 || imm64 !== v_exp64[k]) begin
                bad++;
                $display("FAIL x64_%0d: got v=%b imm=%h expected v=1 imm=%h", k, out_valid64, imm64, v_exp64[k]);
            end
            total++;
            if (imm32 !== v_exp32[k]) begin
                bad++;
                $display("FAIL x32_%0d: got imm=%h expected %h", k, imm32, v_exp32[k]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reserved();
        out_ready = 1'b1;
        in_valid = 1'b1; instr = 32'hFFFFFFFF; imm_src = 3'b111;
        @(posedge clk); #1;
        total++;
        if (out_valid32 !== 1'b1 || imm32 !== 32'h0 || err32 !== 1'b1) begin
            bad++; $display("FAIL rsv32: got v=%b imm=%h err=%b expected v=1 imm=0 err=1", out_valid32, imm32, err32);
        end
        total++;
        if (imm64 !== 64'h0 || err64 !== 1'b1) begin
            bad++; $display("FAIL rsv64: got imm=%h err=%b expected imm=0 err=1", imm64, err64);
        end
        instr = 32'h00500093; imm_src = 3'd0;
        @(posedge clk); #1;
        total++;
        if (out_valid32 !== 1'b1 || imm32 !== 32'h5 || err32 !== 1'b0) begin
            bad++; $display("FAIL rsv_after: got v=%b imm=%h err=%b expected v=1 imm=5 err=0", out_valid32, imm32, err32);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00100093; imm_src = 3'd0;   // A = 1
        @(posedge clk); #1;
        total++;
        if (out_valid32 !== 1'b1 || imm32 !== 32'h1 || in_ready32 !== 1'b1) begin
            bad++; $display("FAIL stall_a: got v=%b imm=%h rdy=%b expected v=1 imm=1 rdy=1", out_valid32, imm32, in_ready32);
        end
        instr = 32'h00200093;                                  // B = 2
        @(posedge clk); #1;
        total++;
        if (in_ready32 !== 1'b0 || imm32 !== 32'h1) begin
            bad++; $display("FAIL stall_full: got rdy=%b imm=%h expected rdy=0 imm=1", in_ready32, imm32);
        end
        instr = 32'h00300093;                                  // ignored while full
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (out_valid32 !== 1'b1 || imm32 !== 32'h1 || in_ready32 !== 1'b0) begin
            bad++; $display("FAIL stall_hold: got v=%b imm=%h rdy=%b expected v=1 imm=1 rdy=0", out_valid32, imm32, in_ready32);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid32 !== 1'b1 || imm32 !== 32'h2 || in_ready32 !== 1'b1) begin
            bad++; $display("FAIL stall_b: got v=%b imm=%h rdy=%b expected v=1 imm=2 rdy=1", out_valid32, imm32, in_ready32);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid32 !== 1'b0) begin
            bad++; $display("FAIL stall_empty: got v=%b expected 0 (extra entry imm=%h)", out_valid32, imm32);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_imm [$];
        logic        exp_err [$];
        int  sent = 0, got = 0, cyc = 0;
        bit  pend = 1'b0;
        logic [31:0] e_imm;
        logic        e_err;
        do_reset();
        while (got < 10000 && cyc < 80000) begin
            if (!pend && sent < 10000 && ($urandom % 4) != 0) begin
                pend = 1'b1;
                instr = $urandom;
                imm_src = 3'($urandom % 8);
            end
            in_valid = pend;
            out_ready = (($urandom % 4) != 0);
            @(negedge clk);
            total++;
            if (in_ready32 !== (exp_imm.size() < 2) || out_valid32 !== (exp_imm.size() > 0)) begin
                bad++;
                $display("FAIL rnd_occ cyc=%0d: got rdy=%b v=%b expected occupancy %0d", cyc, in_ready32, out_valid32, exp_imm.size());
            end
            if (out_valid32 && out_ready && exp_imm.size() > 0) begin
                e_imm = exp_imm.pop_front();
                e_err = exp_err.pop_front();
                got++;
                total++;
                if (imm32 !== e_imm || err32 !== e_err) begin
                    bad++;
                    $display("FAIL rnd_data #%0d: got imm=%h err=%b expected imm=%h err=%b", got, imm32, err32, e_imm, e_err);
                end
            end
            if (in_valid && in_ready32) begin
                exp_imm.push_back(ref32(instr, imm_src));
                exp_err.push_back(imm_src == 3'b111);
                pend = 1'b0;
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        total++;
        if (got != 10000) begin
            bad++; $display("FAIL rnd_timeout: got %0d entries expected 10000", got);
        end
    endtask

    task automatic test_reset_full();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00100093; imm_src = 3'd0;
        @(posedge clk); #1;
        instr = 32'h00200093;
        @(posedge clk); #1;
        total++; if (in_ready32 !== 1'b0) begin bad++; $display("FAIL rf_full: got rdy=%b expected 0", in_ready32); end
        reset = 1'b1; instr = 32'h00300093;
        @(posedge clk); #1;
        total++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || imm32 !== 32'h0 || err32 !== 1'b0) begin
            bad++; $display("FAIL rf_reset: got v=%b rdy=%b imm=%h err=%b expected v=0 rdy=1 imm=0 err=0", out_valid32, in_ready32, imm32, err32);
        end
        reset = 1'b0; out_ready = 1'b1; instr = 32'h00700093;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (out_valid32 !== 1'b1 || imm32 !== 32'h7) begin
            bad++; $display("FAIL rf_first: got v=%b imm=%h expected v=1 imm=7", out_valid32, imm32);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid32 !== 1'b0) begin
            bad++; $display("FAIL rf_stale: got v=%b imm=%h expected v=0", out_valid32, imm32);
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_formats32();
        test_xlen64();
        test_reserved();
        test_stall();
        test_random();
        test_reset_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
